// File: rtl/sram_bus_arbiter.sv
// Two-port SRAM-like bus arbiter: merges CPU instruction and data requests onto one
// master port, round-robin with a grant locked until addr_ok, and routes data_ok in order.
module sram_bus_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,

  output logic        busy,
  output logic        proto_err
);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic             lock_valid_q, lock_valid_d;
  owner_e           lock_owner_q, lock_owner_d;
  owner_e           last_owner_q, last_owner_d;
  logic [DEPTH-1:0] owner_fifo_q, owner_fifo_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  owner_e sel;
  owner_e head;
  logic   sel_req;
  logic   full;
  logic   accept;
  logic   pop;

  // A held lock overrides arbitration so a pending request is never swapped out.
  always_comb begin
    if (lock_valid_q) begin
      sel = lock_owner_q;
    end else if (inst_req && !data_req) begin
      sel = OWNER_INST;
    end else if (data_req && !inst_req) begin
      sel = OWNER_DATA;
    end else if (inst_req && data_req) begin
      sel = (last_owner_q == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    end else begin
      sel = OWNER_INST;
    end
  end

  assign sel_req = (sel == OWNER_DATA) ? data_req : inst_req;
  assign full    = (count_q == CNT_FULL);

  // No bypass when full: a pop in the same cycle does not free a slot until next cycle.
  assign m_req   = !reset && sel_req && !full;
  assign m_wr    = (sel == OWNER_DATA) ? data_wr    : inst_wr;
  assign m_size  = (sel == OWNER_DATA) ? data_size  : inst_size;
  assign m_addr  = (sel == OWNER_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (sel == OWNER_DATA) ? data_wdata : inst_wdata;

  assign accept       = m_req && m_addr_ok;
  assign inst_addr_ok = accept && (sel == OWNER_INST);
  assign data_addr_ok = accept && (sel == OWNER_DATA);

  assign head         = owner_e'(owner_fifo_q[rd_ptr_q]);
  assign pop          = !reset && m_data_ok && (count_q != '0);
  assign inst_data_ok = pop && (head == OWNER_INST);
  assign data_data_ok = pop && (head == OWNER_DATA);
  assign proto_err    = !reset && m_data_ok && (count_q == '0);

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  assign busy = lock_valid_q || (count_q != '0);

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this block leaves a
    // signal unassigned and no latch is inferred; blocking '=' is correct in always_comb.
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    last_owner_d = last_owner_q;
    owner_fifo_d = owner_fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (accept) begin
      owner_fifo_d[wr_ptr_q] = sel;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      last_owner_d           = sel;
      lock_valid_d           = 1'b0;
    end else if (m_req) begin
      lock_valid_d = 1'b1;
      lock_owner_d = sel;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWNER_INST;
      last_owner_q <= OWNER_INST;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      last_owner_q <= last_owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the owner storage is not reset; an entry is only read after it was written,
  // because count gates every pop.
  always_ff @(posedge clk) begin
    owner_fifo_q <= owner_fifo_d;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like master port between the CPU instruction and data request ports. The SRAM-like protocol uses req/wr/size/addr/wdata, addr_ok accept and in-order data_ok/rdata return.
- Sits between the core's inst/data interfaces and the single bus bridge.
- Round-robin arbitration with a locked grant: the granted request holds the port until addr_ok.
- Up to DEPTH accepted transactions may be outstanding. An owner FIFO steers each data_ok back to its requester.

Parameters:
DEPTH, 4, max outstanding accepted-but-not-returned transactions (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  instruction request
inst_wr  in  1  instruction write flag
inst_size  in  2  instruction size
inst_addr  in  32  instruction address
inst_wdata  in  32  instruction write data
inst_rdata  out  32  instruction read data (= m_rdata)
inst_addr_ok  out  1  instruction request accepted
inst_data_ok  out  1  instruction response valid
data_req  in  1  data request
data_wr  in  1  data write flag
data_size  in  2  data size
data_addr  in  32  data address
data_wdata  in  32  data write data
data_rdata  out  32  data read data (= m_rdata)
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
m_req  out  1  master request
m_wr  out  1  master write flag
m_size  out  2  master size
m_addr  out  32  master address
m_wdata  out  32  master write data
m_rdata  in  32  master read data
m_addr_ok  in  1  master request accepted
m_data_ok  in  1  master response valid
busy  out  1  outstanding count != 0 or lock held
proto_err  out  1  one-cycle pulse: m_data_ok seen with owner FIFO empty

Behaviour:
- State registers:
  - lock_valid, lock_owner (0=inst, 1=data).
  - last_owner: reset value inst, so data wins the first tie.
  - owner FIFO: DEPTH entries, 1 bit each.
  - count: width $clog2(DEPTH+1).
- Reset (async): lock_valid=0, count=0, FIFO pointers=0, last_owner=inst. While reset is high, m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok and proto_err are all 0.
- Owner selection, combinational:
  - If lock_valid: sel=lock_owner.
  - Else if only one request is high: sel=that requester.
  - Else if both are high: sel=!last_owner.
  - Else: sel=inst (don't care).
- Master request:
  - m_req = sel's req && count<DEPTH.
  - m_wr/m_size/m_addr/m_wdata mux from sel.
- Accept:
  - sel's addr_ok = m_req && m_addr_ok. The other addr_ok = 0.
  - On accept, push sel into the FIFO, set last_owner=sel and clear lock_valid.
- Lock: if m_req && !m_addr_ok, set lock_valid=1 and lock_owner=sel. Rationale: the protocol forbids changing a pending request before it is accepted.
- Requester withdraws req while locked (protocol violation by requester): m_req drops with it. The lock is retained until that requester re-asserts and is accepted; the other requester waits.
- Response:
  - On m_data_ok with count>0: pop the FIFO head; assert inst_data_ok if head=0, else data_data_ok, for the same cycle (zero latency, combinational).
  - rdata goes to both requesters unconditionally.
  - On m_data_ok with count==0: no data_ok, proto_err=1 for that cycle, count unchanged.
- Count:
  - +1 on accept, -1 on valid pop, unchanged on simultaneous accept+pop.
  - When count==DEPTH, m_req=0 even if a pop occurs that cycle (no bypass). Acceptance resumes the following cycle.
- Same-cycle accept and response: legal. The response belongs to the older head entry; the new entry is pushed behind it.
- FIFO pointers wrap modulo DEPTH.
- busy = lock_valid || count!=0.

Test Plan:
- Reset, then inst_req=1 only; m_addr_ok=1 same cycle. Required: inst_addr_ok=1 in cycle 0. Then m_data_ok=1 with m_rdata=0x1234_5678 one cycle later. Required: inst_data_ok=1, inst_rdata=0x12345678, data_data_ok=0.
- Both req high from reset, m_addr_ok=1 every cycle. Required grants alternate data, inst, data, inst.
- data_req wins with m_addr_ok=0 for 3 cycles while inst_req is also high. Required: m_addr stays data_addr all 3 cycles. Accept on cycle 4 goes to data; inst is granted next.
- DEPTH=4, m_data_ok held 0, inst_req=1. Required: exactly 4 accepts, then m_req=0 and busy=1. One m_data_ok pulse re-enables m_req the next cycle.
- Accepts of order inst,data,data,inst, then 4 m_data_ok pulses. Required data_ok sequence: inst, data, data, inst. Repeat twice to exercise pointer wrap.
- m_data_ok with count=0. Required: proto_err=1 for one cycle, no data_ok, count stays 0.
- Assert reset mid-transaction with count=2 and lock_valid=1. Required: m_req=0 immediately, busy=0 after reset.
